// File: rtl/reg_bank_write_arbiter.sv
// rtl/reg_bank_write_arbiter.sv - register bank shared by NUM_REQ writers, one committed write per cycle
// Define REG_ARB_FIXED_PRIO_EN for lowest-index-wins priority; default is round-robin.
module reg_bank_write_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 2,
    parameter int NUM_REQ   = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDRWIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATAWIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         busy,
    input  logic [ADDRWIDTH-1:0]         rd_addr,
    output logic [DATAWIDTH-1:0]         rd_data
);
    localparam int DEPTH = 2**ADDRWIDTH;

    logic [DATAWIDTH-1:0] bank [DEPTH];
    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 found;
    logic [ADDRWIDTH-1:0] win_addr;
    logic [DATAWIDTH-1:0] win_data;

    // A writer whose grant is currently visible is masked so a held req is not served twice.
    assign elig = req & ~gnt;

`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[i]) begin
                found     = 1'b1;
                win_oh[i] = 1'b1;
            end
        end
    end
`else
    localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTRW-1:0] rr_ptr;
    logic [PTRW-1:0] rr_next;

    // Search starts at rr_ptr and wraps; the pointer moves just past the winner.
    always_comb begin
        int idx;
        idx     = 0;
        win_oh  = '0;
        found   = 1'b0;
        rr_next = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && elig[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                rr_next     = (idx == NUM_REQ - 1) ? '0 : PTRW'(idx + 1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= rr_next;
        end
    end
`endif

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_addr = wr_addr[i*ADDRWIDTH +: ADDRWIDTH];
                win_data = wr_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                bank[a] <= '0;
            end
            gnt  <= '0;
            busy <= 1'b0;
        end else begin
            gnt  <= win_oh;
            busy <= |(elig & ~win_oh);
            if (found) begin
                bank[win_addr] <= win_data;
            end
        end
    end

    assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// tb/tb_reg_bank_write_arbiter.sv - scoreboard bench for reg_bank_write_arbiter (directed + random)
module tb_reg_bank_write_arbiter;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NR = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [NR-1:0] req;
    logic [NR*AW-1:0] wr_addr;
    logic [NR*DW-1:0] wr_data;
    logic [NR-1:0] gnt;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [NR-1:0]   gnt;
        logic            busy;
        logic [4*DW-1:0] bank;
    } exp_t;

    exp_t exp_q[$];

    reg_bank_write_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .NUM_REQ(NR)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state only, updated from the rules at each edge.
    logic [DW-1:0] mbank [4];
    logic [NR-1:0] mgnt;
    int            mrr;

    initial begin
        exp_t e;
        logic [NR-1:0] el;
        int w;
        int cand;
        forever begin
            @(posedge Clk);
            if (Rst) begin
                for (int a = 0; a < 4; a++) mbank[a] = '0;
                mgnt = '0;
                mrr  = 0;
                e.busy = 1'b0;
            end else begin
                el = req & ~mgnt;
                w  = -1;
                for (int k = 0; k < NR; k++) begin
`ifdef REG_ARB_FIXED_PRIO_EN
                    cand = k;
`else
                    cand = (mrr + k) % NR;
`endif
                    if (w < 0 && el[cand]) w = cand;
                end
                if (w >= 0) begin
                    mbank[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
                    mgnt = NR'(1) << w;
                    mrr  = (w + 1) % NR;
                end else begin
                    mgnt = '0;
                end
                e.busy = ($countones(el) > ((w >= 0) ? 1 : 0));
            end
            e.gnt  = mgnt;
            e.bank = {mbank[3], mbank[2], mbank[1], mbank[0]};
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        logic [DW-1:0] exp_rd;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_rd = e.bank[rd_addr*DW +: DW];
                check("mon_gnt", 32'(gnt), 32'(e.gnt));
                check("mon_busy", 32'(busy), 32'(e.busy));
                check("mon_rd_data", 32'(rd_data), 32'(exp_rd));
            end
        end
    end

    task automatic set_writer(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        req = '0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    // Reads every bank entry during the low clock phase; callers drive inputs right after.
    task automatic sweep(input string name, input logic [4*DW-1:0] img);
        @(negedge Clk);
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            #1;
            check(name, 32'(rd_data), 32'(img[a*DW +: DW]));
        end
    endtask

    logic [NR-1:0] pend;

    initial begin
        Rst = 1'b1;
        req = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        // Test 1: preload, then one reset edge clears everything.
        for (int i = 0; i < NR; i++) set_writer(i, AW'(i), DW'($urandom_range(1, 255)));
        req = '1;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        req = '0;
        Rst = 1'b1;
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        sweep("rst_bank", 32'h0);

        // Test 2: lone writer, held req is masked every other cycle.
        set_writer(0, 2'd2, 8'hA5);
        rd_addr = 2'd2;
        req = 4'b0001;
        step();
        check("single_gnt1", 32'(gnt), 32'b0001);
        check("single_rd", 32'(rd_data), 32'hA5);
        step();
        check("single_gnt2", 32'(gnt), 32'b0000);
        step();
        check("single_gnt3", 32'(gnt), 32'b0001);
        @(negedge Clk);
        req = '0;

`ifndef REG_ARB_FIXED_PRIO_EN
        // Test 3: round-robin build-up, then Test 4: same-address serialization.
        do_reset();
        for (int i = 0; i < NR; i++) set_writer(i, AW'(i), DW'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            step();
            check("rr_gnt", 32'(gnt), 32'(1 << k));
            if (k < 3) check("rr_busy", 32'(busy), 32'h1);
        end
        sweep("rr_bank", 32'h13121110);
        set_writer(1, 2'd1, 8'h3C);
        set_writer(3, 2'd1, 8'hC3);
        req = 4'b1010;
        step();
        check("same_addr_gnt1", 32'(gnt), 32'b0010);
        step();
        check("same_addr_gnt2", 32'(gnt), 32'b1000);
        @(negedge Clk);
        req = '0;
        rd_addr = 2'd1;
        #1;
        check("same_addr_final", 32'(rd_data), 32'hC3);
`endif

        // Test 5: reset in mid-sequence discards arbitration state.
        do_reset();
        for (int i = 0; i < NR; i++) set_writer(i, AW'(i), DW'($urandom));
        req = 4'b1111;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        step();
        check("midrst_gnt", 32'(gnt), 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        step();
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        @(negedge Clk);
        req = '0;

`ifdef REG_ARB_FIXED_PRIO_EN
        // Test 6: fixed priority with masking.
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            check("fp_alt", 32'(gnt), (k % 2 == 0) ? 32'b0001 : 32'b0100);
        end
        @(negedge Clk);
        req = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            step();
            check("fp_starve", 32'(gnt[2]), 32'h0);
        end
        @(negedge Clk);
        req = '0;
`endif

        // Random phase: writers follow the hold-until-grant handshake, occasionally abandon.
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            for (int i = 0; i < NR; i++) begin
                if (pend[i] && gnt[i]) begin
                    pend[i] = ($urandom % 2) == 0;
                    if (pend[i]) set_writer(i, AW'($urandom), DW'($urandom));
                end else if (pend[i] && ($urandom % 20) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && ($urandom % 3) == 0) begin
                    pend[i] = 1'b1;
                    set_writer(i, AW'($urandom), DW'($urandom));
                end
            end
            req = pend;
            rd_addr = AW'($urandom);
            Rst = ($urandom % 64) == 0;
        end
        @(negedge Clk);
        Rst = 1'b0;
        req = '0;
        repeat (3) @(posedge Clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
